// File: rtl/mux3_rr_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared mux3/resource pair.
// The arbiter connects through the slave modport and the requester side through master.
interface mux3_rr_arbiter_if;
    logic [2:0] req_i;
    logic [2:0] gnt_o;
    logic [1:0] sel_o;
    logic       rsrc_req_o;
    logic       rsrc_ack_i;
    logic [2:0] done_o;
    logic [2:0] err_o;

    modport master (
        output req_i,
        output rsrc_ack_i,
        input  gnt_o,
        input  sel_o,
        input  rsrc_req_o,
        input  done_o,
        input  err_o
    );

    modport slave (
        input  req_i,
        input  rsrc_ack_i,
        output gnt_o,
        output sel_o,
        output rsrc_req_o,
        output done_o,
        output err_o
    );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for three requesters sharing one mux3-fed resource.
// It holds the grant and the mux3 select until the resource acks or the timeout expires.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no grant; pick the next requester after last_q in rotation
//   BUSY  | one requester granted; wait for rsrc_ack_i or the timeout
module mux3_rr_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic              clk_i,
    input logic              rst_ni,
    mux3_rr_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [0:0]       state_q;
    logic [2:0]       gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0] cand1, cand2, cand3, win_idx;
    logic       win_vld, ack_hit, tmo_hit;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
        case (i)
            2'd0:    return r[0];
            2'd1:    return r[1];
            default: return r[2];
        endcase
    endfunction

    always_comb begin
        cand1   = next_idx(last_q);
        cand2   = next_idx(cand1);
        cand3   = next_idx(cand2);
        win_vld = |bus.req_i;
        win_idx = cand3;
        if (req_at(bus.req_i, cand1)) begin
            win_idx = cand1;
        end else if (req_at(bus.req_i, cand2)) begin
            win_idx = cand2;
        end
    end

    // Ack takes priority over a timeout landing in the same cycle.
    assign ack_hit = (state_q == BUSY) && bus.rsrc_ack_i;
    assign tmo_hit = (state_q == BUSY) && !bus.rsrc_ack_i && (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= 2'b00;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        gnt_q   <= 3'b001 << win_idx;
                        sel_q   <= win_idx;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // sel_q is left alone on release so the mux3 path stays stable.
                    if (ack_hit || tmo_hit) begin
                        last_q  <= sel_q;
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.sel_o      = sel_q;
    assign bus.rsrc_req_o = (state_q == BUSY);
    assign bus.done_o     = ack_hit ? gnt_q : 3'b000;
    assign bus.err_o      = tmo_hit ? gnt_q : 3'b000;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Scenario bench for mux3_rr_arbiter with TIMEOUT=4: expected grants are queued when
// requests are driven and compared when the grant shows up.
module tb_mux3_rr_arbiter;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] sel;
    } exp_t;

    logic clk_i;
    logic rst_ni;
    int   n_pass;
    int   n_total;
    exp_t exp_q[$];

    mux3_rr_arbiter_if bus ();

    mux3_rr_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Structural invariants, checked mid-cycle while out of reset.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            n_total++;
            if (((bus.gnt_o & (bus.gnt_o - 3'd1)) != 3'd0) || (bus.rsrc_req_o !== (|bus.gnt_o))
                || ((|bus.done_o) && (|bus.err_o)) || (bus.sel_o === 2'b11))
                $display("FAIL invariant gnt=%b rsrc_req=%b done=%b err=%b sel=%b",
                         bus.gnt_o, bus.rsrc_req_o, bus.done_o, bus.err_o, bus.sel_o);
            else n_pass++;
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.gnt = 3'(1 << k);
        e.sel = 2'(k);
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        bus.req_i = 3'b000;
        bus.rsrc_ack_i = 1'b0;
        #3;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        bus.req_i = 3'b000;
        bus.rsrc_ack_i = 1'b0;
        #2;
        n_total++;
        if ({bus.gnt_o, bus.sel_o, bus.rsrc_req_o, bus.done_o, bus.err_o} !== 12'd0)
            $display("FAIL reset_outputs got gnt=%b sel=%b rsrc_req=%b done=%b err=%b exp all zero",
                     bus.gnt_o, bus.sel_o, bus.rsrc_req_o, bus.done_o, bus.err_o);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick;
    endtask

    task automatic test_single;
        exp_t e;
        bus.req_i = 3'b010;
        push_exp(1);
        tick;
        e = exp_q.pop_front();
        n_total++;
        if (bus.gnt_o !== e.gnt || bus.sel_o !== e.sel || bus.rsrc_req_o !== 1'b1)
            $display("FAIL single_grant got gnt=%b sel=%b rsrc_req=%b exp gnt=%b sel=%b rsrc_req=1",
                     bus.gnt_o, bus.sel_o, bus.rsrc_req_o, e.gnt, e.sel);
        else n_pass++;
        tick;
        n_total++;
        if (bus.done_o !== 3'b000) $display("FAIL single_no_early_done got=%b exp=000", bus.done_o);
        else n_pass++;
        tick;
        bus.rsrc_ack_i = 1'b1;
        #1;
        n_total++;
        if (bus.done_o !== e.gnt || bus.err_o !== 3'b000)
            $display("FAIL single_done got done=%b err=%b exp done=%b err=000", bus.done_o, bus.err_o, e.gnt);
        else n_pass++;
        tick;
        bus.rsrc_ack_i = 1'b0;
        bus.req_i = 3'b000;
        n_total++;
        if (bus.gnt_o !== 3'b000 || bus.rsrc_req_o !== 1'b0 || bus.sel_o !== 2'b01)
            $display("FAIL single_release got gnt=%b rsrc_req=%b sel=%b exp gnt=000 rsrc_req=0 sel=01",
                     bus.gnt_o, bus.rsrc_req_o, bus.sel_o);
        else n_pass++;
    endtask

    task automatic test_fairness;
        exp_t e;
        logic [2:0] prev;
        do_reset;
        prev = 3'b000;
        for (int i = 0; i < 6; i++) push_exp(i % 3);
        bus.req_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick;
            e = exp_q.pop_front();
            n_total++;
            if (bus.gnt_o !== e.gnt || bus.sel_o !== e.sel || bus.gnt_o === prev)
                $display("FAIL fair_grant_%0d got gnt=%b sel=%b exp gnt=%b sel=%b", i, bus.gnt_o, bus.sel_o, e.gnt, e.sel);
            else n_pass++;
            prev = bus.gnt_o;
            bus.rsrc_ack_i = 1'b1;
            #1;
            n_total++;
            if (bus.done_o !== e.gnt) $display("FAIL fair_done_%0d got=%b exp=%b", i, bus.done_o, e.gnt);
            else n_pass++;
            tick;
            bus.rsrc_ack_i = 1'b0;
            n_total++;
            if (bus.gnt_o !== 3'b000) $display("FAIL fair_idle_%0d got=%b exp=000", i, bus.gnt_o);
            else n_pass++;
        end
        bus.req_i = 3'b000;
        tick;
    endtask

    task automatic test_timeout;
        exp_t e;
        do_reset;
        bus.req_i = 3'b001;
        push_exp(0);
        tick;
        e = exp_q.pop_front();
        n_total++;
        if (bus.gnt_o !== e.gnt) $display("FAIL tmo_grant got=%b exp=%b", bus.gnt_o, e.gnt);
        else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_total++;
            if (bus.err_o !== 3'b000) $display("FAIL tmo_early_err_cycle%0d got=%b exp=000", c, bus.err_o);
            else n_pass++;
            tick;
        end
        #1;
        n_total++;
        if (bus.err_o !== 3'b001 || bus.done_o !== 3'b000)
            $display("FAIL tmo_err got err=%b done=%b exp err=001 done=000", bus.err_o, bus.done_o);
        else n_pass++;
        tick;
        bus.req_i = 3'b101;
        push_exp(2);
        n_total++;
        if (bus.gnt_o !== 3'b000 || bus.err_o !== 3'b000)
            $display("FAIL tmo_release got gnt=%b err=%b exp 000 000", bus.gnt_o, bus.err_o);
        else n_pass++;
        tick;
        e = exp_q.pop_front();
        n_total++;
        if (bus.gnt_o !== e.gnt || bus.sel_o !== e.sel)
            $display("FAIL tmo_next_grant got gnt=%b sel=%b exp gnt=%b sel=%b", bus.gnt_o, bus.sel_o, e.gnt, e.sel);
        else n_pass++;
        bus.rsrc_ack_i = 1'b1;
        tick;
        bus.rsrc_ack_i = 1'b0;
        bus.req_i = 3'b000;
    endtask

    task automatic test_ack_vs_timeout;
        exp_t e;
        do_reset;
        bus.req_i = 3'b001;
        push_exp(0);
        tick;
        e = exp_q.pop_front();
        repeat (3) tick;
        bus.rsrc_ack_i = 1'b1;
        #1;
        n_total++;
        if (bus.done_o !== e.gnt || bus.err_o !== 3'b000)
            $display("FAIL ack_vs_tmo got done=%b err=%b exp done=%b err=000", bus.done_o, bus.err_o, e.gnt);
        else n_pass++;
        tick;
        bus.rsrc_ack_i = 1'b0;
        bus.req_i = 3'b000;
        n_total++;
        if (bus.gnt_o !== 3'b000) $display("FAIL ack_vs_tmo_release got=%b exp=000", bus.gnt_o);
        else n_pass++;
    endtask

    task automatic test_robust;
        exp_t e;
        bus.req_i = 3'b100;
        push_exp(2);
        tick;
        e = exp_q.pop_front();
        bus.req_i = 3'b000;
        tick;
        tick;
        n_total++;
        if (bus.gnt_o !== e.gnt || bus.rsrc_req_o !== 1'b1 || bus.sel_o !== e.sel)
            $display("FAIL drop_req_hold got gnt=%b rsrc_req=%b sel=%b exp gnt=%b rsrc_req=1 sel=%b",
                     bus.gnt_o, bus.rsrc_req_o, bus.sel_o, e.gnt, e.sel);
        else n_pass++;
        bus.rsrc_ack_i = 1'b1;
        #1;
        n_total++;
        if (bus.done_o !== e.gnt) $display("FAIL drop_req_done got=%b exp=%b", bus.done_o, e.gnt);
        else n_pass++;
        tick;
        bus.rsrc_ack_i = 1'b0;
        tick;
        bus.rsrc_ack_i = 1'b1;
        #1;
        n_total++;
        if (bus.done_o !== 3'b000 || bus.err_o !== 3'b000 || bus.gnt_o !== 3'b000)
            $display("FAIL idle_ack_pulse got done=%b err=%b gnt=%b exp all 000", bus.done_o, bus.err_o, bus.gnt_o);
        else n_pass++;
        tick;
        bus.rsrc_ack_i = 1'b0;
        n_total++;
        if (bus.gnt_o !== 3'b000 || bus.rsrc_req_o !== 1'b0 || bus.sel_o !== 2'b10)
            $display("FAIL idle_ack_state got gnt=%b rsrc_req=%b sel=%b exp gnt=000 rsrc_req=0 sel=10",
                     bus.gnt_o, bus.rsrc_req_o, bus.sel_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bus.req_i = 3'b010;
        tick;
        n_total++;
        if (bus.gnt_o !== 3'b010 || bus.sel_o !== 2'b01)
            $display("FAIL rst_mid_pre got gnt=%b sel=%b exp gnt=010 sel=01", bus.gnt_o, bus.sel_o);
        else n_pass++;
        #2;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if (bus.gnt_o !== 3'b000 || bus.rsrc_req_o !== 1'b0 || bus.sel_o !== 2'b00 || bus.done_o !== 3'b000 || bus.err_o !== 3'b000)
            $display("FAIL rst_mid_async got gnt=%b rsrc_req=%b sel=%b done=%b err=%b exp all zero",
                     bus.gnt_o, bus.rsrc_req_o, bus.sel_o, bus.done_o, bus.err_o);
        else n_pass++;
        bus.req_i = 3'b111;
        push_exp(0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick;
        e = exp_q.pop_front();
        n_total++;
        if (bus.gnt_o !== e.gnt || bus.sel_o !== e.sel)
            $display("FAIL rst_mid_first got gnt=%b sel=%b exp gnt=%b sel=%b", bus.gnt_o, bus.sel_o, e.gnt, e.sel);
        else n_pass++;
        bus.rsrc_ack_i = 1'b1;
        tick;
        bus.rsrc_ack_i = 1'b0;
        bus.req_i = 3'b000;
        tick;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset;
        test_single;
        test_fairness;
        test_timeout;
        test_ack_vs_timeout;
        test_robust;
        test_reset_mid;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux3_rr_arbiter.md
# mux3_rr_arbiter

Round-robin arbiter and sequencer for a shared single-port resource whose input path is a 3-way `mux3`. Examples of the resource: the data-memory port, the register-file write port or the ALU operand B path. Three requesters (0, 1, 2) raise requests. The block grants exactly one at a time, drives the `mux3` select `s_i` encoding from its registered `sel_o`, and holds the selection stable until the resource acknowledges or a timeout fires. It sits between the control unit / requesters and the `mux3` + resource pair.

## Interface
- `TIMEOUT`, default 16: cycles in BUSY without ack before abort; 0 disables the timeout.
- `CNT_W`, default 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `req_i`  in  3  per-requester request level; bit k belongs to requester k.
- `gnt_o`  out  3  one-hot registered grant; all-zero when idle.
- `sel_o`  out  2  registered `mux3` select: requester 0→2'b00, 1→2'b01, 2→2'b10; 2'b11 never driven.
- `rsrc_req_o`  out  1  request to the shared resource; high exactly while BUSY.
- `rsrc_ack_i`  in  1  resource completion strobe; sampled only in BUSY.
- `done_o`  out  3  one-cycle completion pulse to the granted requester.
- `err_o`  out  3  one-cycle timeout pulse to the granted requester.

## Operation
- Two-state FSM: IDLE, BUSY.
- Registers: `state_q`, `gnt_q[2:0]`, `sel_q[1:0]`, `last_q[1:0]` (last served index), `cnt_q[CNT_W-1:0]`.
- Reset values: IDLE; `gnt_o`=0, `sel_o`=2'b00, `rsrc_req_o`=0, `done_o`=0, `err_o`=0; `last_q`=2 (requester 0 has first priority); `cnt_q`=0.
- IDLE with `req_i`≠0:
  - Search order is (last_q+1), (last_q+2), (last_q+3), mod 3.
  - The first asserted requester k wins: `gnt_q`←onehot(k), `sel_q`←enc(k), `cnt_q`←0, go to BUSY.
- IDLE with `req_i`=0: hold all state; outputs at their idle values.
- BUSY, `rsrc_ack_i`=1:
  - `done_o` = `gnt_q`, combinational, in the same cycle.
  - Next edge: `last_q`←k, `gnt_q`←0, go to IDLE. `sel_q` keeps its value, so the `mux3` path stays stable.
- BUSY, no ack, TIMEOUT≠0 and `cnt_q`==TIMEOUT-1:
  - `err_o` = `gnt_q` in that cycle.
  - Release exactly as on ack; `last_q`←k.
- BUSY otherwise: `cnt_q` increments and saturates at TIMEOUT-1. If TIMEOUT=0, `cnt_q` holds at 0.
- Ack and timeout in the same cycle: ack wins. `done_o` pulses, `err_o` stays 0.
- Requester k drops `req_i[k]` while granted: ignored; the transaction completes normally. Requesters must hold req until done/err.
- `rsrc_ack_i` while IDLE: ignored; no pulse, no state change.
- `rst_ni` low mid-transaction: immediate return to the reset values. The in-flight transaction is abandoned without `done_o`/`err_o`.
- Invariants:
  - `gnt_o` is always 0 or one-hot.
  - `done_o` and `err_o` are never both non-zero.
  - `rsrc_req_o` == |`gnt_o`.

## Timing
- Request sampled in IDLE at edge N → `gnt_o`, `sel_o`, `rsrc_req_o` valid after edge N.
- Ack in cycle M → `done_o` in cycle M; IDLE after edge M; the earliest next grant appears after edge M+1.
- Minimum transaction spacing is 2 cycles (ack in the first BUSY cycle).
- Timeout: `err_o` asserts in the TIMEOUT-th BUSY cycle, counting the first BUSY cycle as 1.
- `sel_o` changes only on the edge that enters BUSY, never while BUSY.

## Test plan
- Reset then single request: `req_i`=3'b010 → one cycle later `gnt_o`=010, `sel_o`=01, `rsrc_req_o`=1. Ack on the 3rd BUSY cycle → `done_o`=010 that cycle; `gnt_o`=0 the next.
- Fairness: `req_i`=3'b111 held, ack every 1st BUSY cycle → grant order 0,1,2,0,1,2 with `sel_o` 00,01,10,00,01,10; never two consecutive grants to the same requester.
- Timeout: TIMEOUT=4, `req_i`=001, no ack → `err_o`=001 in the 4th BUSY cycle, `done_o`=0, then IDLE. Next with `req_i`=101 → requester 2 is granted.
- Simultaneous ack and timeout: TIMEOUT=4, ack in the 4th BUSY cycle → `done_o` pulses, `err_o`=0.
- Robustness: drop `req_i` during BUSY → grant persists until ack. Pulse `rsrc_ack_i` while IDLE → no output change.
- Reset mid-BUSY: assert `rst_ni`=0 asynchronously between edges → `gnt_o`=0, `rsrc_req_o`=0, `sel_o`=00 immediately. After release, `req_i`=111 → requester 0 is granted first.
